// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-level configuration constants used as defaults by the CPU bus fabric.
package core_v_mini_mcu_pkg;

  localparam int unsigned NUM_CORES = 2;

  // An ID field is never narrower than one bit, even with a single core.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the core-side and bus-side ports.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cpu_obi_id_fifo.sv
// Small FIFO holding the core index of each granted-but-unanswered transaction.
module cpu_obi_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_reg;
  logic [PW-1:0]    rptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_reg != CW'(DEPTH));
  assign do_pop  = pop_i && (count_reg != '0);

  // Head is read combinationally so responses reach the core in the same cycle.
  assign data_o  = mem[rptr_reg];
  assign count_o = count_reg;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wptr_reg] <= data_i;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (do_pop) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_obi_arbiter.sv
// Round-robin OBI arbiter merging several core ports onto one bus port,
// routing in-order responses back by a FIFO of granted core indices.
module cpu_obi_arbiter
  import obi_pkg::*;
#(
  parameter int unsigned NUM_CORES       = core_v_mini_mcu_pkg::NUM_CORES,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IDW = core_v_mini_mcu_pkg::id_width(NUM_CORES),
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  obi_req_t  [NUM_CORES-1:0] core_req_i,
  output obi_resp_t [NUM_CORES-1:0] core_resp_o,
  output obi_req_t                  bus_req_o,
  input  obi_resp_t                 bus_resp_i,
  output logic [CW-1:0]             outstanding_o,
  output logic                      resp_err_o
);

  logic [IDW-1:0] rr_ptr_reg;
  logic           lock_valid_reg;
  logic [IDW-1:0] lock_idx_reg;
  logic           err_reg;

  logic [IDW:0]   cand;
  logic [IDW-1:0] rr_sel;
  logic           rr_found;
  logic           lock_hold;
  logic [IDW-1:0] sel;
  logic           sel_valid;
  logic [IDW-1:0] rr_ptr_next;
  logic [CW-1:0]  count;
  logic [IDW-1:0] head_id;
  logic           full;
  logic           bus_valid;
  logic           handshake;
  logic           rsp_hit;

  // Search upward from rr_ptr with wrap; first requester wins.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = {1'b0, rr_ptr_reg} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_CORES)) begin
        cand = cand - (IDW+1)'(NUM_CORES);
      end
      if (!rr_found && core_req_i[cand[IDW-1:0]].req) begin
        rr_found = 1'b1;
        rr_sel   = cand[IDW-1:0];
      end
    end
  end

  // A pending ungranted request keeps the bus until gnt or until the core drops req.
  assign lock_hold = lock_valid_reg && core_req_i[lock_idx_reg].req;
  assign sel       = lock_hold ? lock_idx_reg : rr_sel;
  assign sel_valid = lock_hold || rr_found;

  assign full      = (count == CW'(MAX_OUTSTANDING));
  assign bus_valid = sel_valid && !full && !rst_i;
  assign bus_req_o = bus_valid ? core_req_i[sel] : '0;
  assign handshake = bus_valid && bus_resp_i.gnt;
  assign rsp_hit   = bus_resp_i.rvalid && (count != '0) && !rst_i;

  assign rr_ptr_next = (sel == IDW'(NUM_CORES - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg     <= '0;
      lock_valid_reg <= 1'b0;
      lock_idx_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr_reg <= rr_ptr_next;
      end
      lock_valid_reg <= bus_valid && !bus_resp_i.gnt;
      lock_idx_reg   <= sel;
      if (bus_resp_i.rvalid && (count == '0)) begin
        err_reg <= 1'b1;
      end
    end
  end

  cpu_obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (rsp_hit),
    .data_o  (head_id),
    .count_o (count)
  );

  genvar gi;
  for (gi = 0; gi < NUM_CORES; gi++) begin : g_resp
    assign core_resp_o[gi].gnt    = handshake && (sel == IDW'(gi));
    assign core_resp_o[gi].rvalid = rsp_hit && (head_id == IDW'(gi));
    assign core_resp_o[gi].rdata  = (rsp_hit && (head_id == IDW'(gi))) ? bus_resp_i.rdata : '0;
  end

  assign outstanding_o = count;
  assign resp_err_o    = err_reg;

endmodule

// File: tb/tb_cpu_obi_arbiter.sv
// Directed plus randomized check of cpu_obi_arbiter against a queue-based
// model of round-robin grants, address locking and in-order response routing.
module tb_cpu_obi_arbiter;
  import obi_pkg::*;

  localparam int N    = 2;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic                clk = 1'b0;
  logic                rst;
  obi_req_t  [N-1:0]   core_req;
  obi_resp_t [N-1:0]   core_resp;
  obi_req_t            bus_req;
  obi_resp_t           bus_resp;
  logic [CW-1:0]       outstanding;
  logic                resp_err;

  int vectors = 0;
  int fails   = 0;

  // Reference model state
  int rr_m;
  bit lock_m;
  int lock_idx_m;
  bit err_m;
  int idq[$];

  always #5 clk = ~clk;

  cpu_obi_arbiter #(
    .NUM_CORES       (N),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .core_req_i    (core_req),
    .core_resp_o   (core_resp),
    .bus_req_o     (bus_req),
    .bus_resp_i    (bus_resp),
    .outstanding_o (outstanding),
    .resp_err_o    (resp_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obi_req_t mk(input bit r, input logic [31:0] a);
    obi_req_t q;
    q       = '0;
    q.req   = r;
    q.we    = 1'($urandom_range(0, 1));
    q.be    = 4'($urandom_range(0, 15));
    q.addr  = a;
    q.wdata = $urandom;
    return q;
  endfunction

  // Called at posedge+1 with inputs already set; checks, then advances one cycle.
  task automatic tick();
    int        sel;
    bit        full;
    bit        breq;
    bit        gnt;
    bit        hit;
    obi_req_t  eb;
    obi_resp_t er;
    #3;
    if (rst) begin
      chk("bus_req_in_reset", 128'(bus_req), 128'(0));
      for (int k = 0; k < N; k++) begin
        chk($sformatf("core%0d_resp_in_reset", k), 128'(core_resp[k]), 128'(0));
      end
      chk("outstanding_in_reset", 128'(outstanding), 128'(idq.size()));
      chk("resp_err_in_reset", 128'(resp_err), 128'(err_m));
      @(posedge clk);
      idq.delete();
      rr_m   = 0;
      lock_m = 1'b0;
      err_m  = 1'b0;
      #1;
      return;
    end
    full = (idq.size() == MAXO);
    sel  = -1;
    if (lock_m && core_req[lock_idx_m].req) begin
      sel = lock_idx_m;
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (rr_m + i) % N;
        if (sel < 0 && core_req[k].req) sel = k;
      end
    end
    breq = !full && (sel >= 0);
    gnt  = breq && bus_resp.gnt;
    hit  = bus_resp.rvalid && (idq.size() > 0);
    eb   = breq ? core_req[sel] : '0;
    chk("bus_req", 128'(bus_req), 128'(eb));
    for (int k = 0; k < N; k++) begin
      er     = '0;
      er.gnt = gnt && (k == sel);
      if (hit && idq[0] == k) begin
        er.rvalid = 1'b1;
        er.rdata  = bus_resp.rdata;
      end
      chk($sformatf("core%0d_resp", k), 128'(core_resp[k]), 128'(er));
    end
    chk("outstanding", 128'(outstanding), 128'(idq.size()));
    chk("resp_err", 128'(resp_err), 128'(err_m));
    @(posedge clk);
    if (hit) void'(idq.pop_front());
    else if (bus_resp.rvalid) err_m = 1'b1;
    if (gnt) begin
      idq.push_back(sel);
      rr_m = (sel + 1) % N;
    end
    lock_m     = breq && !bus_resp.gnt;
    lock_idx_m = sel;
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    core_req   = '0;
    bus_resp   = '0;
    rr_m       = 0;
    lock_m     = 1'b0;
    lock_idx_m = 0;
    err_m      = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Continuous requests from both cores: grants alternate.
    core_req[0]  = mk(1'b1, 32'h10);
    core_req[1]  = mk(1'b1, 32'h20);
    bus_resp.gnt = 1'b1;
    repeat (6) begin
      bus_resp.rvalid = (idq.size() > 0);
      bus_resp.rdata  = $urandom;
      tick();
    end
    bus_resp = '0;

    // Address lock while gnt is withheld.
    reset_pulse();
    core_req[0] = mk(1'b1, 32'h100);
    core_req[1] = mk(1'b1, 32'h200);
    repeat (3) begin
      tick();
      chk("lock_addr", 128'(bus_req.addr), 128'(32'h100));
    end
    bus_resp.gnt = 1'b1;
    tick();
    chk("lock_grant_outstanding", 128'(outstanding), 128'(1));

    // Full stall, then an rvalid frees a slot for the following cycle.
    reset_pulse();
    core_req[0] = mk(1'b1, 32'h300);
    core_req[1] = mk(1'b0, 32'h0);
    bus_resp    = '0;
    bus_resp.gnt = 1'b1;
    repeat (4) tick();
    chk("full_outstanding", 128'(outstanding), 128'(MAXO));
    chk("full_bus_req_low", 128'(bus_req.req), 128'(0));
    bus_resp.rvalid = 1'b1;
    bus_resp.rdata  = 32'h55;
    tick();
    bus_resp.rvalid = 1'b0;
    tick();

    // Response order follows grant order: core1, core0, core1.
    reset_pulse();
    bus_resp     = '0;
    bus_resp.gnt = 1'b1;
    core_req[0]  = mk(1'b0, 32'h0);
    core_req[1]  = mk(1'b1, 32'h400);
    tick();
    core_req[0]  = mk(1'b1, 32'h404);
    core_req[1]  = mk(1'b0, 32'h0);
    tick();
    core_req[0]  = mk(1'b0, 32'h0);
    core_req[1]  = mk(1'b1, 32'h408);
    tick();
    core_req[1]  = mk(1'b0, 32'h0);
    bus_resp.gnt = 1'b0;
    bus_resp.rvalid = 1'b1;
    bus_resp.rdata  = 32'hA;
    tick();
    bus_resp.rdata  = 32'hB;
    tick();
    bus_resp.rdata  = 32'hC;
    tick();

    // Spurious response with nothing in flight; flag stays set.
    bus_resp.rdata = 32'hDEAD;
    tick();
    bus_resp = '0;
    repeat (3) tick();

    // Reset with two transactions in flight.
    core_req[0]  = mk(1'b1, 32'h500);
    core_req[1]  = mk(1'b1, 32'h504);
    bus_resp.gnt = 1'b1;
    repeat (2) tick();
    reset_pulse();
    tick();
    bus_resp.gnt    = 1'b0;
    bus_resp.rvalid = 1'b1;
    bus_resp.rdata  = 32'h77;
    core_req        = '0;
    tick();
    bus_resp = '0;
    tick();

    // Randomized traffic.
    reset_pulse();
    repeat (400) begin
      for (int k = 0; k < N; k++) begin
        core_req[k] = mk($urandom_range(0, 3) != 0, $urandom);
      end
      bus_resp.gnt    = ($urandom_range(0, 3) != 0);
      bus_resp.rvalid = (idq.size() > 0) ? 1'($urandom_range(0, 1))
                                         : ($urandom_range(0, 49) == 0);
      bus_resp.rdata  = $urandom;
      rst             = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
